// File: rtl/isqrt_seq.sv
// isqrt_seq: sequential integer square root, data_out = floor(sqrt(data_in)).
// Restoring digit-by-digit engine that retires one result bit per clock.
// Handshake: a start pulse is sampled in IDLE, and done pulses for one cycle.
// Optional feature macro ISQRT_REM_EN adds output port rem = data_in - data_out^2.
module isqrt_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    output logic [WIDTH/2-1:0] data_out,
`ifdef ISQRT_REM_EN
    output logic [WIDTH/2:0]   rem,
`endif
    output logic               done
);

    localparam int HALF = WIDTH / 2;
    localparam int RW   = HALF + 2;            // partial remainder width
    localparam int CW   = $clog2(HALF + 1);    // iteration counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  rad_sr;
    logic [RW-1:0]     rem_r;
    logic [HALF-1:0]   root_r;
    logic [CW-1:0]     cnt_r;
    logic              load, step, finish;
    logic [RW:0]       step_res;

    // One restoring iteration. Returns {new_root_bit, new_remainder}.
    // The remainder never exceeds 2*root, so dropping its top two bits
    // while shifting in the next radicand pair loses nothing.
    function automatic logic [RW:0] sqrt_step(input logic [RW-1:0]   r,
                                              input logic [1:0]      pair,
                                              input logic [HALF-1:0] q);
        logic [RW-1:0] r_sh;
        logic [RW-1:0] trial;
        r_sh  = {r[RW-3:0], pair};
        trial = {q, 2'b01};
        if (r_sh >= trial)
            sqrt_step = {1'b1, r_sh - trial};
        else
            sqrt_step = {1'b0, r_sh};
    endfunction

    assign step_res = sqrt_step(rem_r, rad_sr[WIDTH-1:WIDTH-2], root_r);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next-state and datapath control decode
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                // The counter reaching zero means every bit is resolved;
                // that extra cycle publishes the result.
                if (cnt_r != '0) begin
                    step = 1'b1;
                end else begin
                    finish     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Iteration datapath: radicand shifter, remainder, root, counter
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_sr <= '0;
            rem_r  <= '0;
            root_r <= '0;
            cnt_r  <= '0;
        end else if (load) begin
            rad_sr <= data_in;
            rem_r  <= '0;
            root_r <= '0;
            cnt_r  <= CW'(HALF);
        end else if (step) begin
            rad_sr <= {rad_sr[WIDTH-3:0], 2'b00};
            rem_r  <= step_res[RW-1:0];
            root_r <= {root_r[HALF-2:0], step_res[RW]};
            cnt_r  <= cnt_r - CW'(1);
        end
    end

    // Result registers: updated only when entering DONE, held otherwise
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            if (finish)
                data_out <= root_r;
        end
    end

`ifdef ISQRT_REM_EN
    // Final remainder published alongside data_out
    always_ff @(posedge clk) begin
        if (rst)
            rem <= '0;
        else if (finish)
            rem <= rem_r[HALF:0];
    end
`endif

endmodule

// File: tb/tb_isqrt_seq.sv
// tb_isqrt_seq: directed self-checking bench for isqrt_seq (WIDTH=16).
// Define ISQRT_REM_EN for both files to also check the rem port.
module tb_isqrt_seq;

    localparam int WIDTH = 16;
    localparam int LAT   = 9;

    logic              clk;
    logic              rst;
    logic              start;
    logic [WIDTH-1:0]  data_in;
    logic [WIDTH/2-1:0] data_out;
    logic              done;
`ifdef ISQRT_REM_EN
    logic [WIDTH/2:0]  rem;
`endif

    int checks = 0;
    int errors = 0;

    isqrt_seq #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .data_out (data_out),
`ifdef ISQRT_REM_EN
        .rem      (rem),
`endif
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, result, pulse width and hold.
    task automatic do_op(input logic [15:0] din, input int exp_root, input int exp_rem);
        int lat;
        lat = -1;
        @(negedge clk);
        start   = 1'b1;
        data_in = din;
        tick();                       // accept edge T
        start   = 1'b0;
        data_in = 16'hA5A5;           // must not disturb the running op
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (done) begin
                lat = n;
                break;
            end
        end
        check($sformatf("latency(%0d)", din), lat, LAT);
        check($sformatf("root(%0d)", din), data_out, exp_root);
`ifdef ISQRT_REM_EN
        check($sformatf("rem(%0d)", din), rem, exp_rem);
`else
        if (exp_rem < 0) $display("note: negative rem %0d", exp_rem);
`endif
        tick();
        check($sformatf("done_drop(%0d)", din), done, 0);
        check($sformatf("hold(%0d)", din), data_out, exp_root);
        tick();                       // idle cycle before next request
    endtask

    initial begin
        int ndone;
        logic [7:0] seen;
        rst     = 1'b1;
        start   = 1'b0;
        data_in = '0;

        // Reset for two cycles, then verify quiet idle state
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;
        check("rst_data_out", data_out, 0);
        check("rst_done", done, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        check("idle_no_done", ndone, 0);
        check("idle_data_out", data_out, 0);

        // Directed values: {radicand, root, remainder}
        do_op(16'd0,     0,   0);
        do_op(16'd2,     1,   1);
        do_op(16'd64,    8,   0);
        do_op(16'd1000,  31,  39);
        do_op(16'd4096,  64,  0);
        do_op(16'd5000,  70,  100);
        do_op(16'd65535, 255, 510);

        // start pulse during CALC must be ignored
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd5000;
        tick();
        start   = 1'b0;
        tick();
        tick();
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd16;
        tick();
        start   = 1'b0;
        ndone = 0;
        seen  = 8'd0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done) begin
                ndone++;
                seen = data_out;
            end
        end
        check("busy_single_done", ndone, 1);
        check("busy_root", seen, 70);
        check("busy_hold", data_out, 70);

        // Reset in the middle of CALC aborts with no done
        @(negedge clk);
        start   = 1'b1;
        data_in = 16'd1000;
        tick();
        start   = 1'b0;
        tick();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        @(negedge clk);
        rst = 1'b0;
        check("abort_data_out", data_out, 0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_data_out_late", data_out, 0);
        do_op(16'd4096, 64, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
